// File: rtl/split_drv_pkg.sv
// rtl/split_drv_pkg.sv - shared types, LFSR constants and candidate stepping for the split assignment driver
// Contents: drv_state_e (IDLE/RUN/DONE), LFSR_TAPS, DEF_LFSR_SEED, next_candidate().
package split_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } drv_state_e;

    // Galois toggle mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] DEF_LFSR_SEED = 32'hACE1_0001;

    // mode=1: one Galois LFSR step; mode=0: plain increment (counter order).
    function automatic logic [31:0] next_candidate(input logic mode, input logic [31:0] state);
        if (mode)
            return {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
        else
            return state + 32'd1;
    endfunction

endpackage

// File: rtl/split_assign_driver_if.sv
// rtl/split_assign_driver_if.sv - controller-side start/result bundle of the split assignment driver
// Signals: start, max_iter (controller -> driver), busy, res_valid/res_ready handshake,
// res_sat, res_vec, res_iter (result). master = solver controller, slave = driver.
interface split_assign_driver_if #(
    parameter int VEC_W = 512,
    parameter int CNT_W = 32
);
    logic             start;
    logic [CNT_W-1:0] max_iter;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic             res_sat;
    logic [VEC_W-1:0] res_vec;
    logic [CNT_W-1:0] res_iter;

    modport master (
        output start, max_iter, res_ready,
        input  busy, res_valid, res_sat, res_vec, res_iter
    );

    modport slave (
        input  start, max_iter, res_ready,
        output busy, res_valid, res_sat, res_vec, res_iter
    );
endinterface

// File: rtl/split_drv_lfsr.sv
// rtl/split_drv_lfsr.sv - 32-bit Galois LFSR with seed load and step enable
// Ports: clk, rst (async, active-high), load (state <= SEED), step (advance one position),
// state (current 32-bit value). load has priority over step.
module split_drv_lfsr
    import split_drv_pkg::*;
#(
    parameter logic [31:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = SEED;
        else if (step)
            state_d = next_candidate(1'b1, state_q);
    end

    // Zero after reset is a lock-up value, but every search loads SEED first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= '0;
        else
            state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/split_assign_driver.sv
// rtl/split_assign_driver.sv - candidate generator and result collector for one split_* checker
// Ports: clk, rst (async, active-high); ctl (split_assign_driver_if.slave: start/max_iter in,
// busy and res_valid/res_ready/res_sat/res_vec/res_iter result handshake);
// assign_o (registered candidate to checker), chk_x_i (checker verdict for assign_o).
// Build option SPLIT_DRV_LFSR_EN: adds input mode and the LFSR candidate order (mode=1).
module split_assign_driver
    import split_drv_pkg::*;
#(
    parameter int VEC_W = 512,
    parameter int CNT_W = 32
`ifdef SPLIT_DRV_LFSR_EN
    , parameter logic [31:0] LFSR_SEED = DEF_LFSR_SEED
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SPLIT_DRV_LFSR_EN
    input  logic                 mode,
`endif
    split_assign_driver_if.slave ctl,
    output logic [VEC_W-1:0]     assign_o,
    input  logic                 chk_x_i
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] iter_q,     iter_d;
    logic [CNT_W-1:0] max_q,      max_d;
    logic [VEC_W-1:0] assign_q,   assign_d;
    logic             sat_q,      sat_d;
    logic [VEC_W-1:0] vec_q,      vec_d;
    logic [CNT_W-1:0] res_iter_q, res_iter_d;

`ifdef SPLIT_DRV_LFSR_EN
    localparam int NSL = (VEC_W + 31) / 32;

    logic        mode_q, mode_d;
    logic        lfsr_load;
    logic        lfsr_step;
    logic [31:0] lfsr_state;

    // Fill the bus with copies of the LFSR word; XOR with the slice index keeps
    // the copies from being identical so every variable sees different bits.
    function automatic logic [VEC_W-1:0] expand(input logic [31:0] s);
        logic [NSL*32-1:0] w;
        for (int j = 0; j < NSL; j++)
            w[j*32 +: 32] = s ^ 32'(j);
        return w[VEC_W-1:0];
    endfunction

    split_drv_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_state)
    );
`endif

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        max_d      = max_q;
        assign_d   = assign_q;
        sat_d      = sat_q;
        vec_d      = vec_q;
        res_iter_d = res_iter_q;
`ifdef SPLIT_DRV_LFSR_EN
        mode_d     = mode_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    if (ctl.max_iter != '0) begin
                        state_d  = S_RUN;
                        iter_d   = '0;
                        max_d    = ctl.max_iter;
                        assign_d = '0;
`ifdef SPLIT_DRV_LFSR_EN
                        mode_d    = mode;
                        lfsr_load = 1'b1;
                        if (mode)
                            assign_d = expand(LFSR_SEED);
`endif
                    end else begin
                        // Empty search: report "no solution" without entering RUN.
                        state_d    = S_DONE;
                        sat_d      = 1'b0;
                        vec_d      = '0;
                        res_iter_d = '0;
                    end
                end
            end
            S_RUN: begin
                if (chk_x_i) begin
                    state_d    = S_DONE;
                    sat_d      = 1'b1;
                    vec_d      = assign_q;
                    res_iter_d = iter_q;
                end else if (iter_q == max_q - CNT_W'(1)) begin
                    state_d    = S_DONE;
                    sat_d      = 1'b0;
                    vec_d      = '0;
                    res_iter_d = max_q;
                end else begin
                    iter_d   = iter_q + CNT_W'(1);
                    assign_d = VEC_W'(iter_d);
`ifdef SPLIT_DRV_LFSR_EN
                    if (mode_q) begin
                        // lfsr_state is the word behind the current candidate,
                        // so the next candidate is built from its successor.
                        lfsr_step = 1'b1;
                        assign_d  = expand(next_candidate(1'b1, lfsr_state));
                    end
`endif
                end
            end
            S_DONE: begin
                if (ctl.res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iter_q     <= '0;
            max_q      <= '0;
            assign_q   <= '0;
            sat_q      <= 1'b0;
            vec_q      <= '0;
            res_iter_q <= '0;
`ifdef SPLIT_DRV_LFSR_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            max_q      <= max_d;
            assign_q   <= assign_d;
            sat_q      <= sat_d;
            vec_q      <= vec_d;
            res_iter_q <= res_iter_d;
`ifdef SPLIT_DRV_LFSR_EN
            mode_q     <= mode_d;
`endif
        end
    end

    assign assign_o      = assign_q;
    assign ctl.busy      = (state_q == S_RUN);
    assign ctl.res_valid = (state_q == S_DONE);
    assign ctl.res_sat   = sat_q;
    assign ctl.res_vec   = vec_q;
    assign ctl.res_iter  = res_iter_q;

endmodule

// File: tb/tb_split_assign_driver.sv
// tb/tb_split_assign_driver.sv - directed self-checking bench for split_assign_driver
module tb_split_assign_driver;

    localparam int VEC_W = 512;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [VEC_W-1:0] assign_o;
    logic             chk_x_i;
    int               chk_sel;
    int               total = 0;
    int               bad   = 0;

    split_assign_driver_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) bus ();

`ifdef SPLIT_DRV_LFSR_EN
    logic mode;
`endif

    split_assign_driver #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SPLIT_DRV_LFSR_EN
        .mode     (mode),
`endif
        .ctl      (bus),
        .assign_o (assign_o),
        .chk_x_i  (chk_x_i)
    );

    always #5 clk = ~clk;

    // Checker stand-in: 0 = never satisfied, 1 = always, 2 = hit at 37, 3 = hit at 2.
    always_comb begin
        case (chk_sel)
            1:       chk_x_i = 1'b1;
            2:       chk_x_i = (assign_o == VEC_W'(37));
            3:       chk_x_i = (assign_o == VEC_W'(2));
            default: chk_x_i = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is seen at the next edge (edge 0); returns 1 time unit into cycle 1.
    task automatic start_run(input logic [CNT_W-1:0] mi);
        bus.start    = 1'b1;
        bus.max_iter = mi;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

`ifdef SPLIT_DRV_LFSR_EN
    function automatic logic [31:0] tb_lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0])
            n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [VEC_W-1:0] tb_expand(input logic [31:0] s);
        logic [VEC_W-1:0] w;
        for (int j = 0; j < VEC_W / 32; j++)
            w[j*32 +: 32] = s ^ j;
        return w;
    endfunction
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.max_iter  = '0;
        bus.res_ready = 1'b0;
        chk_sel       = 0;
`ifdef SPLIT_DRV_LFSR_EN
        mode          = 1'b0;
`endif
        repeat (2) tick();
        check("rst_busy",   bus.busy,      0);
        check("rst_valid",  bus.res_valid, 0);
        check("rst_sat",    bus.res_sat,   0);
        check("rst_vec",    bus.res_vec,   0);
        check("rst_iter",   bus.res_iter,  0);
        check("rst_assign", assign_o,      0);
        rst = 1'b0;
        tick();

        // Immediate hit on candidate 0.
        chk_sel = 1;
        start_run(10);
        check("a_busy_c1",   bus.busy,      1);
        check("a_assign_c1", assign_o,      0);
        check("a_valid_c1",  bus.res_valid, 0);
        tick();
        check("a_valid_c2",  bus.res_valid, 1);
        check("a_sat",       bus.res_sat,   1);
        check("a_vec",       bus.res_vec,   0);
        check("a_iter",      bus.res_iter,  0);
        check("a_busy_c2",   bus.busy,      0);
        handshake();
        check("a_valid_clr", bus.res_valid, 0);
        check("a_sat_held",  bus.res_sat,   1);

        // Hit on candidate 37: busy over cycles 1..38, result in cycle 39.
        chk_sel = 2;
        start_run(100);
        for (int c = 1; c <= 38; c++) begin
            check("b_busy",   bus.busy,      1);
            check("b_valid",  bus.res_valid, 0);
            check("b_assign", assign_o,      VEC_W'(c - 1));
            tick();
        end
        check("b_valid_c39", bus.res_valid, 1);
        check("b_sat",       bus.res_sat,   1);
        check("b_vec",       bus.res_vec,   37);
        check("b_iter",      bus.res_iter,  37);
        check("b_busy_c39",  bus.busy,      0);
        handshake();

        // No hit within 5 candidates.
        chk_sel = 0;
        start_run(5);
        for (int c = 1; c <= 5; c++) begin
            check("c_busy",   bus.busy, 1);
            check("c_assign", assign_o, VEC_W'(c - 1));
            tick();
        end
        check("c_valid",       bus.res_valid, 1);
        check("c_sat",         bus.res_sat,   0);
        check("c_iter",        bus.res_iter,  5);
        check("c_vec",         bus.res_vec,   0);
        check("c_assign_hold", assign_o,      4);
        handshake();
        check("c_valid_clr",   bus.res_valid, 0);

        // Empty search, result held under back-pressure, starts in DONE ignored.
        start_run(0);
        check("d_valid_c1", bus.res_valid, 1);
        check("d_sat",      bus.res_sat,   0);
        check("d_iter",     bus.res_iter,  0);
        check("d_busy",     bus.busy,      0);
        for (int c = 1; c <= 20; c++) begin
            if (c % 5 == 0) begin
                bus.start    = 1'b1;
                bus.max_iter = 9;
            end
            tick();
            bus.start = 1'b0;
            check("d_hold_valid", bus.res_valid, 1);
            check("d_hold_busy",  bus.busy,      0);
            check("d_hold_iter",  bus.res_iter,  0);
            check("d_hold_sat",   bus.res_sat,   0);
        end
        // Start coinciding with the handshake must not launch a search.
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        bus.max_iter  = 3;
        tick();
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check("d_hs_busy",   bus.busy,      0);
        check("d_hs_valid",  bus.res_valid, 0);
        tick();
        check("d_idle_busy", bus.busy,      0);

        // Start during RUN ignored, then async reset at candidate 7.
        chk_sel = 0;
        start_run(50);
        for (int c = 1; c <= 7; c++) begin
            if (c == 4) begin
                bus.start    = 1'b1;
                bus.max_iter = 2;
            end
            tick();
            bus.start = 1'b0;
        end
        check("e_assign_c8", assign_o, 7);
        check("e_busy_c8",   bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("e_rst_busy",   bus.busy,      0);
        check("e_rst_valid",  bus.res_valid, 0);
        check("e_rst_assign", assign_o,      0);
        check("e_rst_sat",    bus.res_sat,   0);
        check("e_rst_vec",    bus.res_vec,   0);
        check("e_rst_iter",   bus.res_iter,  0);
        tick();
        rst = 1'b0;
        tick();
        check("e_idle_busy",  bus.busy,      0);
        chk_sel = 3;
        start_run(50);
        check("e_re_assign0", assign_o, 0);
        check("e_re_busy",    bus.busy, 1);
        tick();
        check("e_re_assign1", assign_o, 1);
        tick();
        check("e_re_assign2", assign_o, 2);
        tick();
        check("e_re_valid",   bus.res_valid, 1);
        check("e_re_sat",     bus.res_sat,   1);
        check("e_re_iter",    bus.res_iter,  2);
        check("e_re_vec",     bus.res_vec,   2);
        handshake();

`ifdef SPLIT_DRV_LFSR_EN
        // Pseudo-random order, twice from the same seed.
        chk_sel = 0;
        mode    = 1'b1;
        for (int r = 0; r < 2; r++) begin
            logic [31:0] s;
            s = 32'hACE1_0001;
            start_run(4);
            for (int c = 1; c <= 4; c++) begin
                check("f_lfsr_assign", assign_o, tb_expand(s));
                s = tb_lfsr_next(s);
                tick();
            end
            check("f_valid", bus.res_valid, 1);
            check("f_sat",   bus.res_sat,   0);
            check("f_iter",  bus.res_iter,  4);
            handshake();
        end
        mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
